sprite_fetch_arbiter: RTL

Shares one synchronous sprite/tile memory read port among up to `NUM_LAYERS` compositor layer fetchers. Each layer fetcher streams pixel reads into its own line buffer ahead of the `compositor` chain. The block does round-robin arbitration with a zero-cycle grant, drives the memory port from a register, and returns read data tagged per layer after the fixed memory latency. `frame_start` is driven from the `vga` vsync edge and realigns priority to layer 0 every frame.

---
 rtl/sprite_fetch_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/sprite_fetch_arbiter.sv
// Round-robin arbiter sharing one sprite memory read port among NUM_LAYERS fetchers.
// Optional build macro SPRITE_ARB_BURST_EN lets the owning layer keep priority for up to MAX_BURST grants.
module sprite_fetch_arbiter #(
    parameter int NUM_LAYERS = 4,
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 12,
    parameter int RD_LAT     = 2,
    parameter int MAX_BURST  = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         frame_start,
    input  logic [NUM_LAYERS-1:0]        req,
    input  logic [NUM_LAYERS*ADDR_W-1:0] addr,
    output logic [NUM_LAYERS-1:0]        gnt,
    output logic                         mem_en,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic [NUM_LAYERS-1:0]        rvalid,
    output logic [DATA_W-1:0]            rdata,
    output logic                         busy
);

    localparam int PTR_W = (NUM_LAYERS > 2) ? $clog2(NUM_LAYERS) : 1;

    if (NUM_LAYERS < 2 || NUM_LAYERS > 8) begin : g_bad_layers
        $error("sprite_fetch_arbiter: NUM_LAYERS must be 2..8");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("sprite_fetch_arbiter: RD_LAT must be 1..4");
    end
    if (MAX_BURST < 1) begin : g_bad_burst
        $error("sprite_fetch_arbiter: MAX_BURST must be at least 1");
    end

    function automatic logic [NUM_LAYERS-1:0] onehot_f(input logic [PTR_W-1:0] idx);
        onehot_f      = '0;
        onehot_f[idx] = 1'b1;
    endfunction

    logic [PTR_W-1:0]      ptr_r;
    logic [PTR_W-1:0]      ptr_nxt_s;
    logic [PTR_W-1:0]      base_s;
    logic [PTR_W:0]        cand_s;
    logic [PTR_W-1:0]      win_s;
    logic [PTR_W-1:0]      win_inc_s;
    logic                  hit_s;
    logic [ADDR_W-1:0]     addr_sel_s;
    logic                  mem_en_r;
    logic [ADDR_W-1:0]     mem_addr_r;
    logic [NUM_LAYERS-1:0] issue_tag_r;
    logic [NUM_LAYERS-1:0] tag_r [RD_LAT];
    logic                  busy_s;

`ifdef SPRITE_ARB_BURST_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] run_s;
`endif

    // Round-robin search from the priority base; frame_start forces layer 0 first.
    always_comb begin
        base_s = frame_start ? '0 : ptr_r;
        hit_s  = 1'b0;
        win_s  = '0;
        cand_s = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            cand_s = {1'b0, base_s} + (PTR_W+1)'(k);
            if (cand_s >= (PTR_W+1)'(NUM_LAYERS)) begin
                cand_s = cand_s - (PTR_W+1)'(NUM_LAYERS);
            end else begin
                cand_s = cand_s;
            end
            if (!hit_s && req[cand_s[PTR_W-1:0]]) begin
                hit_s = 1'b1;
                win_s = cand_s[PTR_W-1:0];
            end else begin
                hit_s = hit_s;
            end
        end
        win_inc_s  = (win_s == PTR_W'(NUM_LAYERS - 1)) ? '0 : win_s + PTR_W'(1);
        addr_sel_s = addr[int'(win_s) * ADDR_W +: ADDR_W];
    end

    // Combinational grant, held off entirely while reset is asserted.
    always_comb begin
        if (rst_n && hit_s) begin
            gnt = onehot_f(win_s);
        end else begin
            gnt = '0;
        end
    end

`ifdef SPRITE_ARB_BURST_EN
    // Burst priority: the owner keeps the pointer until MAX_BURST grants or its req drops.
    always_comb begin
        ptr_nxt_s = ptr_r;
        cnt_nxt_s = cnt_r;
        run_s     = CNT_W'(1);
        if (frame_start) begin
            ptr_nxt_s = hit_s ? win_inc_s : '0;
            cnt_nxt_s = '0;
        end else if (hit_s) begin
            run_s = (cnt_r != '0 && win_s == ptr_r) ? cnt_r + CNT_W'(1) : CNT_W'(1);
            if (run_s >= CNT_W'(MAX_BURST)) begin
                ptr_nxt_s = win_inc_s;
                cnt_nxt_s = '0;
            end else begin
                ptr_nxt_s = win_s;
                cnt_nxt_s = run_s;
            end
        end else if (cnt_r != '0 && !req[ptr_r]) begin
            ptr_nxt_s = (ptr_r == PTR_W'(NUM_LAYERS - 1)) ? '0 : ptr_r + PTR_W'(1);
            cnt_nxt_s = '0;
        end else begin
            ptr_nxt_s = ptr_r;
            cnt_nxt_s = cnt_r;
        end
    end

    // Burst run-length counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end
`else
    // Plain rotation: the pointer moves past every granted layer.
    always_comb begin
        ptr_nxt_s = ptr_r;
        if (frame_start) begin
            ptr_nxt_s = hit_s ? win_inc_s : '0;
        end else if (hit_s) begin
            ptr_nxt_s = win_inc_s;
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end
`endif

    // Priority pointer, memory issue register and layer-tag return pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r       <= '0;
            mem_en_r    <= 1'b0;
            mem_addr_r  <= '0;
            issue_tag_r <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                tag_r[k] <= '0;
            end
        end else begin
            ptr_r       <= ptr_nxt_s;
            mem_en_r    <= hit_s;
            mem_addr_r  <= hit_s ? addr_sel_s : mem_addr_r;
            issue_tag_r <= gnt;
            tag_r[0]    <= issue_tag_r;
            for (int k = 1; k < RD_LAT; k++) begin
                tag_r[k] <= tag_r[k-1];
            end
        end
    end

    // Busy while a read is being issued or any tag is still travelling.
    always_comb begin
        busy_s = mem_en_r;
        for (int k = 0; k < RD_LAT; k++) begin
            busy_s = busy_s | (|tag_r[k]);
        end
    end

    assign mem_en   = mem_en_r;
    assign mem_addr = mem_addr_r;
    assign rvalid   = tag_r[RD_LAT-1];
    assign rdata    = mem_rdata;
    assign busy     = busy_s;

endmodule
